// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multicycle controller and the datapath/memory.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_fsm_if #(
  parameter int ALUOP_W = 2
);
  logic [4:0]         opcode;
  logic [1:0]         condition;
  logic               zFlag;
  logic               mem_ready;
  logic               ir_wr;
  logic               pc_wr;
  logic [1:0]         PCsrc;
  logic [1:0]         RWsrc;
  logic [1:0]         WB;
  logic               RBsrc;
  logic               RegWR;
  logic               ALUsrc;
  logic               MRD;
  logic               MWR;
  logic [ALUOP_W-1:0] ALUop;
  logic [2:0]         state;
  logic               halted;
  logic               ill_op;
  logic               mem_err;

  modport master (
    input  opcode, condition, zFlag, mem_ready,
    output ir_wr, pc_wr, PCsrc, RWsrc, WB, RBsrc, RegWR, ALUsrc, MRD, MWR,
           ALUop, state, halted, ill_op, mem_err
  );

  modport slave (
    output opcode, condition, zFlag, mem_ready,
    input  ir_wr, pc_wr, PCsrc, RWsrc, WB, RBsrc, RegWR, ALUsrc, MRD, MWR,
           ALUop, state, halted, ill_op, mem_err
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshake,
// timeout and HALT. Define CTRL_PREDICATION_EN to enable condition-code predication.
module multicycle_ctrl_fsm #(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_HALT, C_ILL
  } op_class_t;

  localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT);

  state_t     cur_state, nxt_state;
  logic [7:0] tmo_cnt;
  logic [4:0] op_q;
  op_class_t  cls;
  logic       pred_ok;
  logic       tmo_hit;

  logic       ir_wr, pc_wr, rb_src, reg_wr, alu_src, mrd, mwr;
  logic       halted, ill_op, mem_err;
  logic [1:0] pc_src, rw_src, wb_sel, alu_code;

  function automatic op_class_t classify(input logic [4:0] op);
    op_class_t c;
    casez (op)
      5'b000??: c = C_RALU;
      5'b001??: c = C_IALU;
      5'b01000: c = C_LW;
      5'b01001: c = C_SW;
      5'b01010: c = C_BEQ;
      5'b01011: c = C_BNE;
      5'b01100: c = C_J;
      5'b01101: c = C_JAL;
      5'b01110: c = C_JR;
      5'b11111: c = C_HALT;
      default:  c = C_ILL;
    endcase
    return c;
  endfunction

  // Instruction fields are latched on the edge that completes the fetch.
  always_ff @(posedge clk) begin
    if (cur_state == S_FETCH && bus.mem_ready)
      op_q <= bus.opcode;
  end

`ifdef CTRL_PREDICATION_EN
  logic [1:0] cond_q;
  always_ff @(posedge clk) begin
    if (cur_state == S_FETCH && bus.mem_ready)
      cond_q <= bus.condition;
  end
  assign pred_ok = (~cond_q[0] & ~bus.zFlag) | (~cond_q[1] & bus.zFlag);
`else
  logic unused_cond;
  assign unused_cond = ^bus.condition;
  assign pred_ok     = 1'b1;
`endif

  assign cls     = classify(op_q);
  assign tmo_hit = (tmo_cnt == TMO_LIM);

  // Wait counter restarts on every state entry; only FETCH/MEM self-loop on it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_IDLE;
      tmo_cnt   <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state != cur_state)
        tmo_cnt <= 8'd0;
      else if ((cur_state == S_FETCH || cur_state == S_MEM) && !bus.mem_ready)
        tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    pc_src    = 2'b00;
    rw_src    = 2'b00;
    wb_sel    = 2'b00;
    rb_src    = 1'b0;
    reg_wr    = 1'b0;
    alu_src   = 1'b0;
    alu_code  = 2'b00;
    mrd       = 1'b0;
    mwr       = 1'b0;
    halted    = 1'b0;
    ill_op    = 1'b0;
    mem_err   = 1'b0;
    case (cur_state)
      S_IDLE: nxt_state = S_FETCH;
      S_FETCH: begin
        mrd = 1'b1;
        if (bus.mem_ready) begin
          ir_wr     = 1'b1;
          pc_wr     = 1'b1;
          nxt_state = S_DECODE;
        end else if (tmo_hit) begin
          mem_err   = 1'b1;
          nxt_state = S_HALTED;
        end
      end
      S_DECODE: begin
        if (!pred_ok)
          nxt_state = S_FETCH;
        else if (cls == C_ILL) begin
          ill_op    = 1'b1;
          nxt_state = S_FETCH;
        end else if (cls == C_HALT)
          nxt_state = S_HALTED;
        else
          nxt_state = S_EXEC;
      end
      S_EXEC: begin
        nxt_state = S_FETCH;
        case (cls)
          C_RALU: begin
            alu_code  = op_q[1:0];
            nxt_state = S_WB;
          end
          C_IALU: begin
            alu_code  = op_q[1:0];
            alu_src   = 1'b1;
            nxt_state = S_WB;
          end
          C_LW: begin
            alu_src   = 1'b1;
            nxt_state = S_MEM;
          end
          C_SW: begin
            alu_src   = 1'b1;
            rb_src    = 1'b1;
            nxt_state = S_MEM;
          end
          C_BEQ, C_BNE: begin
            alu_code = 2'b01;
            if ((cls == C_BEQ) == bus.zFlag) begin
              pc_wr  = 1'b1;
              pc_src = 2'b01;
            end
          end
          C_J: begin
            pc_wr  = 1'b1;
            pc_src = 2'b10;
          end
          C_JR: begin
            pc_wr  = 1'b1;
            pc_src = 2'b11;
          end
          C_JAL: begin
            pc_wr     = 1'b1;
            pc_src    = 2'b10;
            nxt_state = S_WB;
          end
          default: nxt_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (cls == C_SW) begin
          mwr    = 1'b1;
          rb_src = 1'b1;
        end else
          mrd = 1'b1;
        if (bus.mem_ready)
          nxt_state = (cls == C_SW) ? S_FETCH : S_WB;
        else if (tmo_hit) begin
          mem_err   = 1'b1;
          nxt_state = S_HALTED;
        end
      end
      S_WB: begin
        reg_wr    = 1'b1;
        nxt_state = S_FETCH;
        case (cls)
          C_IALU: rw_src = 2'b01;
          C_LW: begin
            wb_sel = 2'b01;
            rw_src = 2'b01;
          end
          C_JAL: begin
            wb_sel = 2'b10;
            rw_src = 2'b10;
          end
          default: ;
        endcase
      end
      S_HALTED: halted = 1'b1;
      default:  nxt_state = S_IDLE;
    endcase
  end

  assign bus.ir_wr   = ir_wr;
  assign bus.pc_wr   = pc_wr;
  assign bus.PCsrc   = pc_src;
  assign bus.RWsrc   = rw_src;
  assign bus.WB      = wb_sel;
  assign bus.RBsrc   = rb_src;
  assign bus.RegWR   = reg_wr;
  assign bus.ALUsrc  = alu_src;
  assign bus.MRD     = mrd;
  assign bus.MWR     = mwr;
  assign bus.ALUop   = ALUOP_W'(alu_code);
  assign bus.state   = cur_state;
  assign bus.halted  = halted;
  assign bus.ill_op  = ill_op;
  assign bus.mem_err = mem_err;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: per-instruction totals are compared
// against expectations derived from the opcode class, predicate and wait counts.
module tb_multicycle_ctrl_fsm;

  localparam int AW  = 3;
  localparam int TMO = 4;
`ifdef CTRL_PREDICATION_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;

  localparam int K_RALU = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
  localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_HALT = 9, K_ILL = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.ALUOP_W(AW)) bus ();

  multicycle_ctrl_fsm #(.ALUOP_W(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_mis++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int classify(input logic [4:0] op);
    if (op[4:2] == 3'b000) return K_RALU;
    if (op[4:2] == 3'b001) return K_IALU;
    case (op)
      5'b01000: return K_LW;
      5'b01001: return K_SW;
      5'b01010: return K_BEQ;
      5'b01011: return K_BNE;
      5'b01100: return K_J;
      5'b01101: return K_JAL;
      5'b01110: return K_JR;
      5'b11111: return K_HALT;
      default:  return K_ILL;
    endcase
  endfunction

  task automatic do_reset();
    logic [21:0] w;
    @(negedge clk);
    #2;
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode    = 5'd0;
    bus.condition = 2'd0;
    bus.zFlag     = 1'b0;
    #1;
    w = {bus.ir_wr, bus.pc_wr, bus.PCsrc, bus.RWsrc, bus.WB, bus.RBsrc, bus.RegWR,
         bus.ALUsrc, bus.MRD, bus.MWR, bus.ALUop, bus.state, bus.halted, bus.ill_op,
         bus.mem_err};
    check("reset_outputs", int'(w), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state_idle", int'(bus.state), int'(ST_IDLE));
    @(negedge clk);
    check("idle_to_fetch", int'(bus.state), int'(ST_FETCH));
  endtask

  // Runs one instruction from FETCH entry until FETCH is re-entered or HALTED is reached.
  task automatic run_instr(input logic [4:0] op, input logic [1:0] cnd, input bit zd,
                           input bit ze, input int fw, input int mw);
    int k = 0, wcnt = 0;
    logic [2:0] s, prev;
    bit left = 1'b0;
    int o_ir = 0, o_fpc = 0, o_fsrc = 0, o_pcx = 0, o_psrc = 0, o_reg = 0, o_wb = 0;
    int o_rw = 0, o_mrd = 0, o_mwr = 0, o_ill = 0, o_err = 0, o_rb = 0, o_alu = 0;
    int o_asrc = 0, o_dec = 0, o_exe = 0, o_mem = 0, o_wbn = 0, o_stray = 0;
    int cls, e_fc, e_mc, e_cyc;
    bit e_fto, go;
    int e_ir = 0, e_fpc = 0, e_pcx = 0, e_psrc = 0, e_wb = 0, e_rw = 0, e_mrd = 0;
    int e_mwr = 0, e_ill = 0, e_err = 0, e_rb = 0, e_alu = 0, e_asrc = 0, e_dec = 0;
    int e_exe = 0, e_mem = 0, e_wbn = 0, e_halt = 0;
    logic [4:0] hw;

    // expected behaviour from the instruction rules
    cls   = classify(op);
    e_fto = (fw > TMO);
    e_fc  = e_fto ? TMO + 1 : fw + 1;
    e_mrd = e_fc;
    e_err = e_fto ? 1 : 0;
    e_halt = e_fto ? 1 : 0;
    if (!e_fto) begin
      e_ir = 1; e_fpc = 1; e_dec = 1;
      go = PRED_EN ? ((!cnd[0] && !zd) || (!cnd[1] && zd)) : 1'b1;
      if (go) begin
        if (cls == K_ILL) e_ill = 1;
        else if (cls == K_HALT) e_halt = 1;
        else begin
          e_exe = 1;
          e_mc  = (mw > TMO) ? TMO + 1 : mw + 1;
          case (cls)
            K_RALU: begin e_alu = int'(op[1:0]); e_wbn = 1; end
            K_IALU: begin e_alu = int'(op[1:0]); e_asrc = 1; e_wbn = 1; e_rw = 1; end
            K_LW: begin
              e_asrc = 1; e_mem = e_mc; e_mrd += e_mc;
              if (mw > TMO) begin e_err = 1; e_halt = 1; end
              else begin e_wbn = 1; e_wb = 1; e_rw = 1; end
            end
            K_SW: begin
              e_asrc = 1; e_mem = e_mc; e_mwr = e_mc; e_rb = 1 + e_mc;
              if (mw > TMO) begin e_err = 1; e_halt = 1; end
            end
            K_BEQ: begin e_alu = 1; if (ze) begin e_pcx = 1; e_psrc = 1; end end
            K_BNE: begin e_alu = 1; if (!ze) begin e_pcx = 1; e_psrc = 1; end end
            K_J:   begin e_pcx = 1; e_psrc = 2; end
            K_JR:  begin e_pcx = 1; e_psrc = 3; end
            K_JAL: begin e_pcx = 1; e_psrc = 2; e_wbn = 1; e_wb = 2; e_rw = 2; end
            default: ;
          endcase
        end
      end
    end
    e_cyc = e_fc + e_dec + e_exe + e_mem + e_wbn;

    check("start_in_fetch", int'(bus.state), int'(ST_FETCH));
    prev = 3'd7;
    for (k = 0; k < 400; k++) begin
      s = bus.state;
      if (s == ST_HALTED) break;
      if (s != ST_FETCH) left = 1'b1;
      if (left && s == ST_FETCH) break;
      if (s != prev) wcnt = 0;
      bus.opcode    = (s == ST_FETCH) ? op  : 5'($urandom);
      bus.condition = (s == ST_FETCH) ? cnd : 2'($urandom);
      bus.zFlag     = (s == ST_EXEC) ? ze : (s == ST_DECODE) ? zd : 1'($urandom);
      bus.mem_ready = (s == ST_FETCH) ? (wcnt >= fw) :
                      (s == ST_MEM)   ? (wcnt >= mw) : 1'($urandom);
      #1;
      if (bus.ir_wr) o_ir++;
      if (bus.pc_wr) begin
        if (s == ST_FETCH) begin o_fpc++; o_fsrc |= int'(bus.PCsrc); end
        else begin o_pcx++; o_psrc = int'(bus.PCsrc); end
      end
      if (bus.RegWR) begin o_reg++; o_wb = int'(bus.WB); o_rw = int'(bus.RWsrc); end
      if (bus.MRD) o_mrd++;
      if (bus.MWR) o_mwr++;
      if (bus.ill_op) o_ill++;
      if (bus.mem_err) o_err++;
      if (bus.RBsrc) o_rb++;
      if (s == ST_EXEC) begin o_alu = int'(bus.ALUop); o_asrc = int'(bus.ALUsrc); o_exe++; end
      if (s == ST_DECODE) o_dec++;
      if (s == ST_MEM) o_mem++;
      if (s == ST_WB) o_wbn++;
      if (bus.halted || (((bus.WB != 2'b00) || (bus.RWsrc != 2'b00)) && !bus.RegWR) ||
          ((bus.ALUop != '0 || bus.ALUsrc) && s != ST_EXEC) || (bus.ir_wr && s != ST_FETCH))
        o_stray++;
      @(negedge clk);
      wcnt++;
      prev = s;
    end
    s = bus.state;

    check("cycles", k, e_cyc);
    check("end_state", int'(s), e_halt ? int'(ST_HALTED) : int'(ST_FETCH));
    check("ir_wr", o_ir, e_ir);
    check("fetch_pc_wr", o_fpc, e_fpc);
    check("fetch_pcsrc", o_fsrc, 0);
    check("exec_pc_wr", o_pcx, e_pcx);
    check("exec_pcsrc", o_psrc, e_psrc);
    check("regwr", o_reg, e_wbn);
    check("wb_sel", o_wb, e_wb);
    check("rw_sel", o_rw, e_rw);
    check("mrd_cycles", o_mrd, e_mrd);
    check("mwr_cycles", o_mwr, e_mwr);
    check("ill_op", o_ill, e_ill);
    check("mem_err", o_err, e_err);
    check("rbsrc_cycles", o_rb, e_rb);
    check("alu_op", o_alu, e_alu);
    check("alu_src", o_asrc, e_asrc);
    check("decode_cycles", o_dec, e_dec);
    check("exec_cycles", o_exe, e_exe);
    check("mem_cycles", o_mem, e_mem);
    check("wb_cycles", o_wbn, e_wbn);
    check("stray_outputs", o_stray, 0);

    if (s == ST_HALTED) begin
      for (int h = 0; h < 3; h++) begin
        bus.mem_ready = 1'($urandom);
        bus.opcode    = 5'($urandom);
        #1;
        hw = {bus.ir_wr, bus.pc_wr, bus.RegWR, bus.MRD, bus.MWR};
        check("halted_flag", int'(bus.halted), 1);
        check("halted_hold", int'(bus.state), int'(ST_HALTED));
        check("halted_enables", int'(hw), 0);
        @(negedge clk);
      end
      do_reset();
    end
  endtask

  task automatic reset_mid_mem();
    int n = 0;
    while (bus.state != ST_MEM && n < 10) begin
      bus.opcode    = 5'b01000;
      bus.condition = 2'b00;
      bus.zFlag     = 1'b0;
      bus.mem_ready = (bus.state == ST_FETCH);
      @(negedge clk);
      n++;
    end
    check("mid_mem_reached", int'(bus.state), int'(ST_MEM));
    bus.mem_ready = 1'b0;
    #1;
    check("mid_mem_mrd", int'(bus.MRD), 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_mem_abort_state", int'(bus.state), int'(ST_IDLE));
    check("mid_mem_abort_mrd", int'(bus.MRD), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_to_fetch", int'(bus.state), int'(ST_FETCH));
  endtask

  initial begin
    logic [4:0] op;
    logic [1:0] cnd;
    int r, fw, mw;
    bus.opcode    = 5'd0;
    bus.condition = 2'd0;
    bus.zFlag     = 1'b0;
    bus.mem_ready = 1'b0;
    do_reset();

    run_instr(5'b00010, 2'b00, 1'b0, 1'b0, 0, 0);
    run_instr(5'b01000, 2'b00, 1'b0, 1'b0, 0, 3);
    run_instr(5'b01010, 2'b00, 1'b0, 1'b1, 0, 0);
    run_instr(5'b01010, 2'b00, 1'b0, 1'b0, 0, 0);
    run_instr(5'b01011, 2'b00, 1'b1, 1'b0, 1, 0);
    run_instr(5'b00111, 2'b11, 1'b0, 1'b0, 0, 0);
    run_instr(5'b00101, 2'b01, 1'b1, 1'b0, 0, 0);
    run_instr(5'b10000, 2'b00, 1'b0, 1'b0, 0, 0);
    run_instr(5'b01001, 2'b00, 1'b0, 1'b0, 2, 2);
    run_instr(5'b01101, 2'b00, 1'b0, 1'b0, 0, 0);
    run_instr(5'b01100, 2'b00, 1'b0, 1'b0, 0, 0);
    run_instr(5'b01110, 2'b00, 1'b0, 1'b0, 0, 0);
    run_instr(5'b00101, 2'b00, 1'b0, 1'b0, TMO, 0);
    run_instr(5'b01000, 2'b00, 1'b0, 1'b0, 0, TMO);
    run_instr(5'b00000, 2'b00, 1'b0, 1'b0, 20, 0);
    run_instr(5'b01001, 2'b00, 1'b0, 1'b0, 0, 20);
    reset_mid_mem();
    run_instr(5'b11111, 2'b00, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      if (r < 4)       op = {3'b000, 2'($urandom)};
      else if (r < 6)  op = {3'b001, 2'($urandom)};
      else if (r < 8)  op = 5'b01000;
      else if (r < 10) op = 5'b01001;
      else if (r == 10) op = 5'b01010;
      else if (r == 11) op = 5'b01011;
      else if (r == 12) op = 5'b01100;
      else if (r == 13) op = 5'b01101;
      else if (r == 14) op = 5'b01110;
      else if (r == 15) op = 5'b11111;
      else if (r == 16) op = 5'($urandom_range(16, 30));
      else if (r == 17) op = 5'b01111;
      else             op = 5'($urandom);
      cnd = 2'($urandom);
      fw  = ($urandom_range(0, 11) == 0) ? $urandom_range(TMO + 1, TMO + 2) : $urandom_range(0, TMO);
      mw  = ($urandom_range(0, 11) == 0) ? $urandom_range(TMO + 1, TMO + 2) : $urandom_range(0, TMO);
      run_instr(op, cnd, 1'($urandom), 1'($urandom), fw, mw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
